reorder_buffer: RTL and testbench

In-order retirement buffer sitting directly downstream of rename. Each renamed instruction is allocated a slot tagged with its ROB index. Completion broadcasts from the common data bus mark slots done, and the oldest done slot retires one per cycle. On retirement the block returns the superseded physical register to the free list.

---
 rtl/reorder_buffer.sv | 120 ++++++++++++
 tb/tb_reorder_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: rename allocates slots at the tail, the CDB marks them done,
// and the oldest done slot retires one per cycle, releasing its superseded physical register.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PREG_W = 5,
  parameter int AREG_W = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,

  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  input  logic              alloc_rd_en_i,
  input  logic [AREG_W-1:0] alloc_rd_addr_i,
  input  logic [PREG_W-1:0] alloc_prd_addr_i,
  input  logic [PREG_W-1:0] alloc_old_prd_addr_i,
  input  logic [31:0]       alloc_pc_i,
  output logic [IDX_W-1:0]  alloc_tag_o,

  input  logic              cdb_en_i,
  input  logic [IDX_W-1:0]  cdb_tag_i,

  output logic              commit_valid_o,
  output logic              commit_rd_en_o,
  output logic [AREG_W-1:0] commit_rd_addr_o,
  output logic [PREG_W-1:0] commit_prd_addr_o,
  output logic [31:0]       commit_pc_o,

  output logic              reg_free_en_o,
  output logic [PREG_W-1:0] reg_free_addr_o,

  output logic [IDX_W:0]    count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [IDX_W:0] PTR_ONE = 1;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [IDX_W:0]    head_q, tail_q;
  logic [IDX_W-1:0]  head_idx, tail_idx;

  logic [DEPTH-1:0]  valid_q, done_q, rd_en_q;
  logic [AREG_W-1:0] rd_addr_q [DEPTH];
  logic [PREG_W-1:0] prd_q     [DEPTH];
  logic [PREG_W-1:0] old_prd_q [DEPTH];
  logic [31:0]       pc_q      [DEPTH];

  logic alloc_fire, retire_fire;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  assign full_o        = (head_q[IDX_W] != tail_q[IDX_W]) && (head_idx == tail_idx);
  assign empty_o       = (head_q == tail_q);
  assign count_o       = tail_q - head_q;
  assign alloc_ready_o = !full_o;
  assign alloc_tag_o   = tail_idx;

  assign alloc_fire  = alloc_valid_i && alloc_ready_o;
  assign retire_fire = valid_q[head_idx] && done_q[head_idx];

  // Hardwired x0 never owns a physical register worth returning.
  assign reg_free_en_o = commit_valid_o && commit_rd_en_o && (commit_rd_addr_o != '0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q            <= '0;
      tail_q            <= '0;
      valid_q           <= '0;
      done_q            <= '0;
      commit_valid_o    <= 1'b0;
      commit_rd_en_o    <= 1'b0;
      commit_rd_addr_o  <= '0;
      commit_prd_addr_o <= '0;
      commit_pc_o       <= '0;
      reg_free_addr_o   <= '0;
    end else if (flush_i) begin
      head_q         <= '0;
      tail_q         <= '0;
      valid_q        <= '0;
      done_q         <= '0;
      commit_valid_o <= 1'b0;
    end else begin
      commit_valid_o <= retire_fire;
      if (cdb_en_i && valid_q[cdb_tag_i]) begin
        done_q[cdb_tag_i] <= 1'b1;
      end
      if (retire_fire) begin
        valid_q[head_idx] <= 1'b0;
        head_q            <= head_q + PTR_ONE;
        commit_rd_en_o    <= rd_en_q[head_idx];
        commit_rd_addr_o  <= rd_addr_q[head_idx];
        commit_prd_addr_o <= prd_q[head_idx];
        commit_pc_o       <= pc_q[head_idx];
        reg_free_addr_o   <= old_prd_q[head_idx];
      end
      // Head and tail slots only coincide when empty or full, so these writes never collide.
      if (alloc_fire) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
        tail_q            <= tail_q + PTR_ONE;
      end
    end
  end

  // Payload needs no reset: it is only read while the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    if (alloc_fire && !flush_i) begin
      rd_en_q[tail_idx]   <= alloc_rd_en_i;
      rd_addr_q[tail_idx] <= alloc_rd_addr_i;
      prd_q[tail_idx]     <= alloc_prd_addr_i;
      old_prd_q[tail_idx] <= alloc_old_prd_addr_i;
      pc_q[tail_idx]      <= alloc_pc_i;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: stimulus pushes expected retirements into a queue,
// a negedge monitor pops and compares every commit the DUT presents.
module tb_reorder_buffer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic        alloc_valid_i;
  logic        alloc_ready_o;
  logic        alloc_rd_en_i;
  logic [4:0]  alloc_rd_addr_i;
  logic [4:0]  alloc_prd_addr_i;
  logic [4:0]  alloc_old_prd_addr_i;
  logic [31:0] alloc_pc_i;
  logic [3:0]  alloc_tag_o;
  logic        cdb_en_i;
  logic [3:0]  cdb_tag_i;
  logic        commit_valid_o;
  logic        commit_rd_en_o;
  logic [4:0]  commit_rd_addr_o;
  logic [4:0]  commit_prd_addr_o;
  logic [31:0] commit_pc_o;
  logic        reg_free_en_o;
  logic [4:0]  reg_free_addr_o;
  logic [4:0]  count_o;
  logic        full_o;
  logic        empty_o;

  reorder_buffer #(.DEPTH(16), .IDX_W(4), .PREG_W(5), .AREG_W(5)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_rd_en_i(alloc_rd_en_i), .alloc_rd_addr_i(alloc_rd_addr_i),
    .alloc_prd_addr_i(alloc_prd_addr_i), .alloc_old_prd_addr_i(alloc_old_prd_addr_i),
    .alloc_pc_i(alloc_pc_i), .alloc_tag_o(alloc_tag_o),
    .cdb_en_i(cdb_en_i), .cdb_tag_i(cdb_tag_i),
    .commit_valid_o(commit_valid_o), .commit_rd_en_o(commit_rd_en_o),
    .commit_rd_addr_o(commit_rd_addr_o), .commit_prd_addr_o(commit_prd_addr_o),
    .commit_pc_o(commit_pc_o), .reg_free_en_o(reg_free_en_o),
    .reg_free_addr_o(reg_free_addr_o), .count_o(count_o),
    .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rd_en;
    logic [4:0]  rd;
    logic [4:0]  prd;
    logic [4:0]  old;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   commit_cyc_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented commit must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (commit_valid_o === 1'b1) begin
      commit_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got pc %0h expected no commit", commit_pc_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("commit_pc", commit_pc_o, e.pc);
        chk("commit_rd_en", {31'b0, commit_rd_en_o}, {31'b0, e.rd_en});
        chk("commit_rd_addr", {27'b0, commit_rd_addr_o}, {27'b0, e.rd});
        chk("commit_prd", {27'b0, commit_prd_addr_o}, {27'b0, e.prd});
        chk("free_addr", {27'b0, reg_free_addr_o}, {27'b0, e.old});
        chk("free_en", {31'b0, reg_free_en_o},
            {31'b0, (e.rd_en && (e.rd != 5'd0))});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic alloc(input logic rd_en, input logic [4:0] rd, input logic [4:0] prd,
                       input logic [4:0] old, input logic [31:0] pc, input bit accept);
    exp_t e;
    alloc_valid_i        = 1'b1;
    alloc_rd_en_i        = rd_en;
    alloc_rd_addr_i      = rd;
    alloc_prd_addr_i     = prd;
    alloc_old_prd_addr_i = old;
    alloc_pc_i           = pc;
    if (accept) begin
      e.rd_en = rd_en; e.rd = rd; e.prd = prd; e.old = old; e.pc = pc;
      exp_q.push_back(e);
    end
    tick();
    alloc_valid_i = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] tag);
    cdb_en_i  = 1'b1;
    cdb_tag_i = tag;
    tick();
    cdb_en_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    reset_i = 1'b1; flush_i = 1'b0; alloc_valid_i = 1'b0; alloc_rd_en_i = 1'b0;
    alloc_rd_addr_i = '0; alloc_prd_addr_i = '0; alloc_old_prd_addr_i = '0;
    alloc_pc_i = '0; cdb_en_i = 1'b0; cdb_tag_i = '0;
    idle(2);
    reset_i = 1'b0;
    idle(2);

    // Reset / idle state
    chk("rst_empty", {31'b0, empty_o}, 32'd1);
    chk("rst_ready", {31'b0, alloc_ready_o}, 32'd1);
    chk("rst_count", {27'b0, count_o}, 32'd0);
    chk("rst_commit_valid", {31'b0, commit_valid_o}, 32'd0);
    chk("rst_free_en", {31'b0, reg_free_en_o}, 32'd0);
    chk("rst_tag", {28'b0, alloc_tag_o}, 32'd0);

    // Out-of-order completion, in-order retirement
    for (int i = 0; i < 3; i++) begin
      chk("a_tag", {28'b0, alloc_tag_o}, i);
      alloc(1'b1, 5'd5, 5'(7 + i), 5'(5 + i), 32'h100 + 4 * i, 1'b1);
    end
    chk("a_count3", {27'b0, count_o}, 32'd3);
    cdb(4'd2);
    chk("a_young_done_waits", {31'b0, commit_valid_o}, 32'd0);
    cdb(4'd0);
    chk("a_no_same_edge", {31'b0, commit_valid_o}, 32'd0);
    cdb(4'd1);
    chk("a_min_latency", {31'b0, commit_valid_o}, 32'd1);
    idle(4);
    chk("a_commits", commit_cyc_q.size(), 32'd3);
    if (commit_cyc_q.size() == 3)
      chk("a_back_to_back", commit_cyc_q[2] - commit_cyc_q[1], 32'd1);
    chk("a_count0", {27'b0, count_o}, 32'd0);
    chk("a_drained", exp_q.size(), 32'd0);

    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    tick();

    // Fill, refuse, wrap
    for (int i = 0; i < 16; i++)
      alloc(1'b1, 5'(i + 1), 5'(i), 5'(i + 16), 32'h200 + 4 * i, 1'b1);
    chk("b_full", {31'b0, full_o}, 32'd1);
    chk("b_ready", {31'b0, alloc_ready_o}, 32'd0);
    chk("b_count16", {27'b0, count_o}, 32'd16);
    alloc(1'b1, 5'd1, 5'd1, 5'd1, 32'hdead, 1'b0);
    chk("b_drop_count", {27'b0, count_o}, 32'd16);
    chk("b_drop_tag", {28'b0, alloc_tag_o}, 32'd0);
    cdb(4'd0);
    alloc(1'b1, 5'd2, 5'd2, 5'd2, 32'hbeef, 1'b0);
    chk("b_refuse_during_retire", {27'b0, count_o}, 32'd15);
    chk("b_ready_after", {31'b0, alloc_ready_o}, 32'd1);
    chk("b_wrap_tag", {28'b0, alloc_tag_o}, 32'd0);
    alloc(1'b1, 5'd7, 5'd20, 5'd21, 32'h300, 1'b1);
    chk("b_refill", {27'b0, count_o}, 32'd16);
    for (int t = 1; t < 16; t++) cdb(4'(t));
    cdb(4'd0);
    idle(3);
    chk("b_empty", {31'b0, empty_o}, 32'd1);
    chk("b_drained", exp_q.size(), 32'd0);

    // Simultaneous alloc + retire, invalid CDB, no-free commits
    alloc(1'b1, 5'd4, 5'd10, 5'd11, 32'h400, 1'b1);
    alloc(1'b0, 5'd3, 5'd12, 5'd13, 32'h404, 1'b1);
    alloc(1'b1, 5'd0, 5'd14, 5'd15, 32'h408, 1'b1);
    alloc(1'b1, 5'd6, 5'd16, 5'd17, 32'h40c, 1'b1);
    alloc(1'b1, 5'd7, 5'd18, 5'd19, 32'h410, 1'b1);
    chk("c_count5", {27'b0, count_o}, 32'd5);
    cdb(4'd1);
    chk("c_tag6", {28'b0, alloc_tag_o}, 32'd6);
    alloc(1'b1, 5'd8, 5'd22, 5'd23, 32'h414, 1'b1);
    chk("c_alloc_retire_count", {27'b0, count_o}, 32'd5);
    cdb(4'd10);
    idle(2);
    chk("c_invalid_cdb_count", {27'b0, count_o}, 32'd5);
    chk("c_invalid_cdb_nocommit", {31'b0, commit_valid_o}, 32'd0);
    for (int t = 2; t <= 6; t++) cdb(4'(t));
    idle(3);
    chk("c_empty", {31'b0, empty_o}, 32'd1);
    chk("c_drained", exp_q.size(), 32'd0);

    // Flush with 7 entries, 3 done, head ready to retire at the flush edge
    for (int i = 0; i < 7; i++)
      alloc(1'b1, 5'(i + 1), 5'(i), 5'(i + 8), 32'h600 + 4 * i, 1'b1);
    cdb(4'd9);
    cdb(4'd10);
    cdb(4'd7);
    chk("e_count7", {27'b0, count_o}, 32'd7);
    chk("e_pending7", exp_q.size(), 32'd7);
    exp_q.delete();
    flush_i = 1'b1; alloc_valid_i = 1'b1; alloc_pc_i = 32'hf00;
    cdb_en_i = 1'b1; cdb_tag_i = 4'd11;
    tick();
    flush_i = 1'b0; alloc_valid_i = 1'b0; cdb_en_i = 1'b0;
    chk("e_count0", {27'b0, count_o}, 32'd0);
    chk("e_empty", {31'b0, empty_o}, 32'd1);
    chk("e_tag0", {28'b0, alloc_tag_o}, 32'd0);
    chk("e_commit_valid", {31'b0, commit_valid_o}, 32'd0);
    chk("e_free_en", {31'b0, reg_free_en_o}, 32'd0);
    chk("e_pc_held", commit_pc_o, 32'h414);
    idle(3);
    alloc(1'b1, 5'd9, 5'd3, 5'd4, 32'h700, 1'b1);
    cdb(4'd0);
    idle(3);
    chk("e_post_flush_drained", exp_q.size(), 32'd0);

    // Asynchronous reset while a commit is presented
    alloc(1'b1, 5'd2, 5'd5, 5'd6, 32'h800, 1'b1);
    alloc(1'b1, 5'd3, 5'd7, 5'd8, 32'h804, 1'b1);
    cdb(4'd1);
    cdb(4'd2);
    chk("f_commit_before_rst", {31'b0, commit_valid_o}, 32'd1);
    chk("f_pending", exp_q.size(), 32'd2);
    #1 reset_i = 1'b1;
    #1;
    chk("f_rst_commit_valid", {31'b0, commit_valid_o}, 32'd0);
    chk("f_rst_free_en", {31'b0, reg_free_en_o}, 32'd0);
    chk("f_rst_pc", commit_pc_o, 32'd0);
    chk("f_rst_count", {27'b0, count_o}, 32'd0);
    chk("f_rst_empty", {31'b0, empty_o}, 32'd1);
    exp_q.delete();
    tick();
    reset_i = 1'b0;
    idle(3);
    chk("final_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
